// File: rtl/spi_adc_slave_pkg.sv
// Shared definitions for spi_adc_slave: FSM state encoding and command bit positions.
// The TAIL state exists only when SPI_ADC_LSBF_EN is defined.
package spi_adc_slave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_NULLB = 3'd2,
        ST_DATA  = 3'd3,
`ifdef SPI_ADC_LSBF_EN
        ST_TAIL  = 3'd4,
`endif
        ST_DONE  = 3'd5
    } state_t;

    // Command bits are shifted in MSB first, so after capture cmd = {SGL, ODD, MSBF}
    localparam int CMD_SGL  = 2;
    localparam int CMD_ODD  = 1;
`ifdef SPI_ADC_LSBF_EN
    localparam int CMD_MSBF = 0;
`endif

endpackage

// File: rtl/spi_adc_slave_sync_edge.sv
// Multi-stage synchronizer for one asynchronous SPI line with registered
// rise/fall pulses; pulse latency is SYNC_STAGES+1 clocks from the input edge.
module spi_adc_slave_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] stages_r;
    logic                   prev_r;

    // Synchronizer chain, previous-value register and edge pulses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stages_r <= {SYNC_STAGES{1'b0}};
            prev_r   <= 1'b0;
            rise_o   <= 1'b0;
            fall_o   <= 1'b0;
        end else begin
            stages_r <= {stages_r[SYNC_STAGES-2:0], d_i};
            prev_r   <= stages_r[SYNC_STAGES-1];
            rise_o   <= stages_r[SYNC_STAGES-1] & ~prev_r;
            fall_o   <= ~stages_r[SYNC_STAGES-1] & prev_r;
        end
    end

endmodule

// File: rtl/spi_adc_slave.sv
// SPI responder modelling a 2-channel ADC: decodes START/SGL/ODD/MSBF, returns null bit + result MSB first.
// Optional macro SPI_ADC_LSBF_EN: MSBF=0 appends an LSB-first trailer D1..D(N-1).
module spi_adc_slave
    import spi_adc_slave_pkg::*;
#(
    parameter int DATA_WIDTH  = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cs_i,
    input  logic                  dclk_i,
    input  logic                  mosi_i,
    output logic                  miso_o,
    output logic                  miso_oe_o,
    input  logic [DATA_WIDTH-1:0] ch0_i,
    input  logic [DATA_WIDTH-1:0] ch1_i,
    output logic                  busy_o,
    output logic [1:0]            ch_sel_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int               CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ODD  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MSBF = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_WIDTH);
`ifdef SPI_ADC_LSBF_EN
    localparam logic [CNT_W-1:0] CNT_TAIL = CNT_W'(DATA_WIDTH - 1);
`endif

    logic                  cs_rise_s, cs_fall_s, dclk_rise_s, dclk_fall_s;
    logic [SYNC_STAGES:0]  mosi_pipe_r;
    logic                  mosi_s;
    state_t                state_r, next_state_s;
    logic [CNT_W-1:0]      cnt_r, cnt_next_s;
    logic [2:0]            cmd_r, cmd_next_s;
    logic [DATA_WIDTH-1:0] shift_r, shift_next_s, result_s;
    logic [DATA_WIDTH:0]   diff_s;
    logic                  miso_next_s, oe_next_s, busy_next_s, done_next_s, err_next_s;
    logic [1:0]            sel_next_s;

    spi_adc_slave_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk_i (clk_i), .rst_i (rst_i), .d_i (cs_i), .rise_o (cs_rise_s), .fall_o (cs_fall_s)
    );

    spi_adc_slave_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_dclk_sync (
        .clk_i (clk_i), .rst_i (rst_i), .d_i (dclk_i), .rise_o (dclk_rise_s), .fall_o (dclk_fall_s)
    );

    // MOSI gets one extra stage so it lines up with the registered dclk edge pulses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mosi_pipe_r <= {(SYNC_STAGES + 1){1'b0}};
        end else begin
            mosi_pipe_r <= {mosi_pipe_r[SYNC_STAGES-1:0], mosi_i};
        end
    end
    assign mosi_s = mosi_pipe_r[SYNC_STAGES];

    // Result select; differential modes use a signed N+1-bit difference clamped at zero
    always_comb begin
        if (cmd_r[CMD_ODD]) begin
            diff_s = {1'b0, ch1_i} - {1'b0, ch0_i};
        end else begin
            diff_s = {1'b0, ch0_i} - {1'b0, ch1_i};
        end
        if (cmd_r[CMD_SGL]) begin
            result_s = cmd_r[CMD_ODD] ? ch1_i : ch0_i;
        end else if (diff_s[DATA_WIDTH]) begin
            result_s = {DATA_WIDTH{1'b0}};
        end else begin
            result_s = diff_s[DATA_WIDTH-1:0];
        end
    end

    // Next-state and next-output logic
    always_comb begin
        next_state_s = state_r;
        cnt_next_s   = cnt_r;
        cmd_next_s   = cmd_r;
        shift_next_s = shift_r;
        miso_next_s  = miso_o;
        oe_next_s    = miso_oe_o;
        busy_next_s  = busy_o;
        sel_next_s   = ch_sel_o;
        done_next_s  = 1'b0;
        err_next_s   = 1'b0;
        if (cs_rise_s) begin
            // busy is set exactly from START until the frame completes, so it marks an abort
            err_next_s   = busy_o;
            next_state_s = ST_IDLE;
            miso_next_s  = 1'b0;
            oe_next_s    = 1'b0;
            busy_next_s  = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cs_fall_s) begin
                        next_state_s = ST_CMD;
                        cnt_next_s   = CNT_ZERO;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end
                ST_CMD: begin
                    if (dclk_rise_s && !busy_o) begin
                        busy_next_s = mosi_s;
                        oe_next_s   = mosi_s;
                        miso_next_s = 1'b0;
                        cnt_next_s  = CNT_ZERO;
                    end else if (dclk_rise_s) begin
                        cmd_next_s = {cmd_r[1:0], mosi_s};
                        cnt_next_s = cnt_r + CNT_ONE;
                        if (cnt_r == CNT_ODD) begin
                            sel_next_s = {cmd_r[0], mosi_s};
                        end else begin
                            sel_next_s = ch_sel_o;
                        end
                        if (cnt_r == CNT_MSBF) begin
                            next_state_s = ST_NULLB;
                        end else begin
                            next_state_s = ST_CMD;
                        end
                    end else begin
                        next_state_s = ST_CMD;
                    end
                end
                ST_NULLB: begin
                    if (dclk_fall_s) begin
                        shift_next_s = result_s;
                        miso_next_s  = 1'b0;
                        cnt_next_s   = CNT_ZERO;
                        next_state_s = ST_DATA;
                    end else begin
                        next_state_s = ST_NULLB;
                    end
                end
                ST_DATA: begin
                    // Rotate rather than shift so the result is intact again for the trailer
                    if (dclk_fall_s && (cnt_r != CNT_DATA)) begin
                        miso_next_s  = shift_r[DATA_WIDTH-1];
                        shift_next_s = {shift_r[DATA_WIDTH-2:0], shift_r[DATA_WIDTH-1]};
                        cnt_next_s   = cnt_r + CNT_ONE;
                    end else if (dclk_rise_s && (cnt_r == CNT_DATA)) begin
`ifdef SPI_ADC_LSBF_EN
                        if (!cmd_r[CMD_MSBF]) begin
                            next_state_s = ST_TAIL;
                            cnt_next_s   = CNT_ZERO;
                        end else begin
                            done_next_s  = 1'b1;
                            busy_next_s  = 1'b0;
                            miso_next_s  = 1'b0;
                            next_state_s = ST_DONE;
                        end
`else
                        done_next_s  = 1'b1;
                        busy_next_s  = 1'b0;
                        miso_next_s  = 1'b0;
                        next_state_s = ST_DONE;
`endif
                    end else begin
                        next_state_s = ST_DATA;
                    end
                end
`ifdef SPI_ADC_LSBF_EN
                ST_TAIL: begin
                    if (dclk_fall_s && (cnt_r != CNT_TAIL)) begin
                        miso_next_s  = shift_r[1];
                        shift_next_s = {shift_r[0], shift_r[DATA_WIDTH-1:1]};
                        cnt_next_s   = cnt_r + CNT_ONE;
                    end else if (dclk_rise_s && (cnt_r == CNT_TAIL)) begin
                        done_next_s  = 1'b1;
                        busy_next_s  = 1'b0;
                        miso_next_s  = 1'b0;
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_TAIL;
                    end
                end
`endif
                ST_DONE: begin
                    miso_next_s  = 1'b0;
                    next_state_s = ST_DONE;
                end
                default: begin
                    next_state_s = ST_IDLE;
                    oe_next_s    = 1'b0;
                    busy_next_s  = 1'b0;
                    miso_next_s  = 1'b0;
                end
            endcase
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            cmd_r     <= 3'b000;
            shift_r   <= {DATA_WIDTH{1'b0}};
            miso_o    <= 1'b0;
            miso_oe_o <= 1'b0;
            busy_o    <= 1'b0;
            ch_sel_o  <= 2'b00;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            cnt_r     <= cnt_next_s;
            cmd_r     <= cmd_next_s;
            shift_r   <= shift_next_s;
            miso_o    <= miso_next_s;
            miso_oe_o <= oe_next_s;
            busy_o    <= busy_next_s;
            ch_sel_o  <= sel_next_s;
            done_o    <= done_next_s;
            err_o     <= err_next_s;
        end
    end

endmodule

// File: tb/tb_spi_adc_slave.sv
// Self-checking bench for spi_adc_slave: bit-banged SPI master with random timing,
// directed literal frames plus random frames checked against a behavioural ADC model.
module tb_spi_adc_slave;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cs_i = 1'b1;
    logic        dclk_i = 1'b0;
    logic        mosi_i = 1'b0;
    logic        miso_o, miso_oe_o, busy_o, done_o, err_o;
    logic [11:0] ch0_i = 12'h000;
    logic [11:0] ch1_i = 12'h000;
    logic [1:0]  ch_sel_o;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    spi_adc_slave dut (
        .clk_i (clk_i), .rst_i (rst_i), .cs_i (cs_i), .dclk_i (dclk_i), .mosi_i (mosi_i),
        .miso_o (miso_o), .miso_oe_o (miso_oe_o), .ch0_i (ch0_i), .ch1_i (ch1_i),
        .busy_o (busy_o), .ch_sel_o (ch_sel_o), .done_o (done_o), .err_o (err_o)
    );

    always #5 clk_i = ~clk_i;

    // Count high cycles of the single-cycle pulses
    always @(negedge clk_i) begin
        if (done_o) done_cnt++;
        if (err_o) err_cnt++;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // ADC behaviour: single-ended picks a channel, differential subtracts and clamps at zero
    function automatic logic [11:0] model(input logic sgl, input logic odd,
                                          input logic [11:0] c0, input logic [11:0] c1);
        int a, b, d;
        if (sgl) return odd ? c1 : c0;
        a = odd ? int'(c1) : int'(c0);
        b = odd ? int'(c0) : int'(c1);
        d = a - b;
        if (d < 0) d = 0;
        return 12'(d);
    endfunction

    // mode 0: full frame; mode 1: cs raised after stop_at rises; mode 2: rst_i after stop_at rises
    task automatic frame(input int lead, input logic sgl, input logic odd, input logic msbf,
                         input logic [11:0] c0, input logic [11:0] c1, input logic [11:0] expv,
                         input int stop_at, input int mode);
        int hp, nr, k, d0, e0, expbit;
        hp = $urandom_range(4, 7);
        ch0_i = c0;
        ch1_i = c1;
        nr = lead + 17;
`ifdef SPI_ADC_LSBF_EN
        if (!msbf) nr = nr + 11;
`endif
        if (mode != 0) nr = stop_at;
        d0 = done_cnt;
        e0 = err_cnt;
        cs_i = 1'b0;
        wait_clk(hp);
        for (int i = 0; i < nr; i++) begin
            if (i < lead) mosi_i = 1'b0;
            else if (i == lead) mosi_i = 1'b1;
            else if (i == lead + 1) mosi_i = sgl;
            else if (i == lead + 2) mosi_i = odd;
            else if (i == lead + 3) mosi_i = msbf;
            else mosi_i = 1'($urandom_range(0, 1));
            wait_clk(hp);
            if (i >= lead + 4) begin
                k = i - lead - 4;
                if (k == 0) expbit = 0;
                else if (k <= 12) expbit = int'(expv[12 - k]);
                else expbit = int'(expv[k - 12]);
                check($sformatf("miso_bit%0d", k), int'(miso_o), expbit);
            end
            if (i > lead) begin
                check("miso_oe_active", int'(miso_oe_o), 1);
                check("busy_active", int'(busy_o), 1);
            end
            if (mode == 0 && i == nr - 1) check("done_not_early", done_cnt, d0);
            dclk_i = 1'b1;
            if (i == lead + 6) begin
                ch0_i = 12'($urandom);
                ch1_i = 12'($urandom);
            end
            wait_clk(hp);
            dclk_i = 1'b0;
        end
        if (mode == 2) begin
            rst_i = 1'b1;
            wait_clk(1);
            check("rst_miso", int'(miso_o), 0);
            check("rst_oe", int'(miso_oe_o), 0);
            check("rst_busy", int'(busy_o), 0);
            check("rst_ch_sel", int'(ch_sel_o), 0);
            check("rst_done", int'(done_o), 0);
            check("rst_err", int'(err_o), 0);
            rst_i = 1'b0;
            wait_clk(hp);
            cs_i = 1'b1;
            wait_clk(8);
            check("rst_no_done", done_cnt, d0);
            check("rst_no_err", err_cnt, e0);
        end else if (mode == 1) begin
            wait_clk(hp);
            cs_i = 1'b1;
            wait_clk(8);
            check("abort_err_count", err_cnt, (stop_at > lead) ? e0 + 1 : e0);
            check("abort_oe", int'(miso_oe_o), 0);
            check("abort_busy", int'(busy_o), 0);
            check("abort_no_done", done_cnt, d0);
        end else begin
            wait_clk(hp);
            check("done_count", done_cnt, d0 + 1);
            check("busy_after_done", int'(busy_o), 0);
            check("ch_sel", int'(ch_sel_o), int'({sgl, odd}));
            cs_i = 1'b1;
            wait_clk(8);
            check("no_err", err_cnt, e0);
            check("oe_after_cs", int'(miso_oe_o), 0);
            check("miso_after_cs", int'(miso_o), 0);
        end
        wait_clk(4);
    endtask

    initial begin
        logic sgl, odd, msbf;
        logic [11:0] c0, c1;
        wait_clk(5);
        check("reset_miso", int'(miso_o), 0);
        check("reset_oe", int'(miso_oe_o), 0);
        check("reset_busy", int'(busy_o), 0);
        check("reset_ch_sel", int'(ch_sel_o), 0);
        check("reset_done", int'(done_o), 0);
        check("reset_err", int'(err_o), 0);
        rst_i = 1'b0;
        wait_clk(10);

        // Literal expectations pinning the channel/difference rules
        frame(0, 1'b1, 1'b0, 1'b1, 12'hABC, 12'h555, 12'hABC, 0, 0);
        frame(0, 1'b1, 1'b1, 1'b1, 12'h0F0, 12'h123, 12'h123, 0, 0);
        frame(0, 1'b0, 1'b0, 1'b1, 12'h100, 12'h200, 12'h000, 0, 0);
        frame(0, 1'b0, 1'b1, 1'b1, 12'h100, 12'h200, 12'h100, 0, 0);
        frame(3, 1'b1, 1'b0, 1'b1, 12'hABC, 12'h000, 12'hABC, 0, 0);
        frame(0, 1'b1, 1'b0, 1'b1, 12'hABC, 12'h000, 12'hABC, 6, 1);
        frame(0, 1'b1, 1'b1, 1'b1, 12'h000, 12'h3C5, 12'h3C5, 0, 0);
        frame(3, 1'b1, 1'b0, 1'b1, 12'h777, 12'h000, 12'h777, 2, 1);
        frame(0, 1'b1, 1'b0, 1'b0, 12'hABC, 12'h000, 12'hABC, 0, 0);
        frame(0, 1'b1, 1'b0, 1'b1, 12'h5A5, 12'h000, 12'h5A5, 10, 2);
        frame(1, 1'b0, 1'b0, 1'b1, 12'h800, 12'h001, 12'h7FF, 0, 0);

        for (int n = 0; n < 24; n++) begin
            sgl = 1'($urandom_range(0, 1));
            odd = 1'($urandom_range(0, 1));
            msbf = 1'($urandom_range(0, 1));
            c0 = 12'($urandom);
            c1 = 12'($urandom);
            frame($urandom_range(0, 3), sgl, odd, msbf, c0, c1, model(sgl, odd, c0, c1), 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
